// File: rtl/gf_pkg.sv
// Shared types for the sequential GF(2) arithmetic unit.
// Op encoding, FSM state, counter width helper.
package gf_pkg;

  typedef enum logic [1:0] {
    GF_ADD    = 2'd0,
    GF_CLMUL  = 2'd1,
    GF_MODMUL = 2'd2,
    GF_RSVD   = 2'd3
  } gf_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } gf_state_e;

  function automatic int gf_cnt_w(input int w, input int bpc);
    return $clog2(w / bpc + 1);
  endfunction

endpackage

// File: rtl/gf_horner_step.sv
// One MSB-first Horner step: acc_out = (acc_in<<1) [mod poly] ^ (mbit ? a : 0).
// Ports: acc_in/acc_out (2W-1 bits), a, poly (W bits), mbit, reduce_en.
module gf_horner_step #(
  parameter int W = 32
) (
  input  logic [2*W-2:0] acc_in,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   poly,
  input  logic           mbit,
  input  logic           reduce_en,
  output logic [2*W-2:0] acc_out
);

  localparam int AW = 2 * W - 1;

  logic [AW-1:0] shifted;
  logic [AW-1:0] reduced;

  always_comb begin
    shifted = acc_in << 1;
    reduced = shifted;
    // modular mode keeps acc W bits wide; bit W-1 is the x^W overflow
    if (reduce_en) begin
      reduced = '0;
      reduced[W-1:0] = shifted[W-1:0] ^ (acc_in[W-1] ? poly : '0);
    end
    acc_out = reduced ^ (mbit ? {{(W - 1){1'b0}}, a} : '0);
  end

endmodule

// File: rtl/gf_seq_multiplier.sv
// Multi-cycle GF(2) unit: XOR add, carry-less multiply, GF(2^W) modmul.
// Ports: in_valid/in_ready/op/a/b/poly in, out_valid/out_ready/result_lo/result_hi/out_err out.
module gf_seq_multiplier
  import gf_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [1:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] poly,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result_lo,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  out_err
);

  localparam int W   = DATA_WIDTH;
  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = W / BPC;
  localparam int AW  = 2 * W - 1;
  localparam int CW  = gf_cnt_w(W, BPC);

  if ((W < 2) || (BPC < 1) || (W % BPC != 0)) begin : g_bad_cfg
    $fatal(1, "gf_seq_multiplier: BITS_PER_CYCLE must divide DATA_WIDTH >= 2");
  end

  gf_state_e     state, state_nx;
  gf_op_e        op_q;
  logic [W-1:0]  a_q, b_q, poly_q;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [W-1:0]  res_lo, res_hi;
  logic          err_q;
  logic          accept, last, op_mul;

  logic [AW-1:0] chain [0:BPC];

  assign accept = in_valid & in_ready;
  assign last   = (cnt == CW'(N - 1));
  assign op_mul = (op == GF_CLMUL) || (op == GF_MODMUL);

  assign chain[0] = acc;

  for (genvar i = 0; i < BPC; i++) begin : g_step
    gf_horner_step #(.W(W)) u_step (
      .acc_in    (chain[i]),
      .a         (a_q),
      .poly      (poly_q),
      .mbit      (b_q[W-1-i]),
      .reduce_en (op_q == GF_MODMUL),
      .acc_out   (chain[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (accept) state_nx = op_mul ? BUSY : DONE;
      BUSY: if (last) state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    result_lo = res_lo;
    result_hi = res_hi;
    out_err   = err_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= GF_ADD;
      a_q    <= '0;
      b_q    <= '0;
      poly_q <= '0;
      acc    <= '0;
      cnt    <= '0;
      res_lo <= '0;
      res_hi <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= gf_op_e'(op);
      a_q    <= a;
      b_q    <= b;
      poly_q <= poly;
      acc    <= '0;
      cnt    <= '0;
      err_q  <= (op == GF_RSVD);
      res_hi <= '0;
      res_lo <= (op == GF_ADD) ? (a ^ b) : '0;
    end else if (state == BUSY) begin
      acc <= chain[BPC];
      b_q <= b_q << BPC;
      cnt <= cnt + CW'(1);
      if (last) begin
        res_lo <= chain[BPC][W-1:0];
        res_hi <= (op_q == GF_CLMUL) ? {1'b0, chain[BPC][AW-1:W]} : '0;
      end
    end
  end

endmodule
